// File: rtl/stm_trace_unpack_pkg.sv
// Shared Debug NoC definitions for the STM trace unpacker: lisnoc16 flit type
// codes, the soft-trace packet class, and the packet-assembly state encoding.
package stm_trace_unpack_pkg;

    localparam logic [1:0] FLIT16_TYPE_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT16_TYPE_HEADER  = 2'b01;
    localparam logic [1:0] FLIT16_TYPE_LAST    = 2'b10;
    localparam logic [1:0] FLIT16_TYPE_SINGLE  = 2'b11;

    localparam logic [2:0] DBG_NOC_CLASS_SOFT_TRACE_DATA = 3'h3;

    // Record layout inside trace_out
    localparam int TRACE_TS_LSB   = 48;
    localparam int TRACE_R3_LSB   = 16;
    localparam int TRACE_INSN_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TS_MSB,
        S_TS_LSB,
        S_R3_MSB,
        S_R3_LSB,
        S_INSTR,
        S_DROP
    } state_t;

endpackage

// File: rtl/stm_trace_unpack.sv
// Rebuilds one 80-bit software-trace record per 6-flit Debug NoC packet;
// malformed packets are dropped and counted in a saturating error counter.
module stm_trace_unpack
    import stm_trace_unpack_pkg::*;
#(
    parameter int DBG_NOC_DATA_WIDTH      = 16,
    parameter int DBG_NOC_FLIT_TYPE_WIDTH = 2,
    parameter int DBG_NOC_PH_DEST_WIDTH   = 5,
    parameter int DBG_NOC_PH_CLASS_WIDTH  = 3,
    parameter int ERR_CNT_WIDTH           = 8
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [DBG_NOC_FLIT_TYPE_WIDTH+DBG_NOC_DATA_WIDTH-1:0] dbgnoc_in_flit,
    input  logic                                            dbgnoc_in_valid,
    output logic                                            dbgnoc_in_ready,
    output logic [5*DBG_NOC_DATA_WIDTH-1:0]                 trace_out,
    output logic [DBG_NOC_DATA_WIDTH-DBG_NOC_PH_DEST_WIDTH-DBG_NOC_PH_CLASS_WIDTH-1:0] trace_core_id,
    output logic                                            trace_out_valid,
    input  logic                                            trace_out_ready,
    output logic                                            err_drop,
    output logic [ERR_CNT_WIDTH-1:0]                        err_count
);

    localparam int D    = DBG_NOC_DATA_WIDTH;
    localparam int ID_W = D - DBG_NOC_PH_DEST_WIDTH - DBG_NOC_PH_CLASS_WIDTH;

    state_t state, state_next;

    logic [DBG_NOC_FLIT_TYPE_WIDTH-1:0] flit_type;
    logic [D-1:0]                       flit_data;
    logic [DBG_NOC_PH_CLASS_WIDTH-1:0]  hdr_class;
    logic                               accept, is_hdr, is_pay, is_last, hdr_ok;
    logic                               err_now, latch_id, load_out;

    logic [2*D-1:0] ts, r3;
    logic [ID_W-1:0] asm_id;

    assign flit_type = dbgnoc_in_flit[DBG_NOC_FLIT_TYPE_WIDTH+D-1:D];
    assign flit_data = dbgnoc_in_flit[D-1:0];
    assign hdr_class = flit_data[D-DBG_NOC_PH_DEST_WIDTH-1 -: DBG_NOC_PH_CLASS_WIDTH];

    assign is_hdr  = (flit_type == FLIT16_TYPE_HEADER);
    assign is_pay  = (flit_type == FLIT16_TYPE_PAYLOAD);
    // A single-flit packet terminates whatever is in progress, same as LAST
    assign is_last = (flit_type == FLIT16_TYPE_LAST) || (flit_type == FLIT16_TYPE_SINGLE);
    assign hdr_ok  = (hdr_class == DBG_NOC_CLASS_SOFT_TRACE_DATA);

    // Only stall when the final flit would overwrite an undelivered record
    assign dbgnoc_in_ready = !((state == S_INSTR) && trace_out_valid && !trace_out_ready);
    assign accept          = dbgnoc_in_valid && dbgnoc_in_ready;

    always_comb begin
        state_next = state;
        err_now    = 1'b0;
        latch_id   = 1'b0;
        load_out   = 1'b0;
        if (accept) begin
            if (is_hdr) begin
                // Any header restarts assembly; it aborts a packet in progress
                latch_id   = hdr_ok;
                state_next = hdr_ok ? S_TS_MSB : S_DROP;
                err_now    = !hdr_ok || ((state != S_IDLE) && (state != S_DROP));
            end else begin
                case (state)
                    S_IDLE:   err_now = 1'b1;
                    S_TS_MSB, S_TS_LSB, S_R3_MSB, S_R3_LSB: begin
                        if (is_pay) begin
                            case (state)
                                S_TS_MSB: state_next = S_TS_LSB;
                                S_TS_LSB: state_next = S_R3_MSB;
                                S_R3_MSB: state_next = S_R3_LSB;
                                default:  state_next = S_INSTR;
                            endcase
                        end else begin
                            err_now    = 1'b1;
                            state_next = S_IDLE;
                        end
                    end
                    S_INSTR: begin
                        if (is_last) begin
                            load_out   = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            err_now    = 1'b1;
                            state_next = S_DROP;
                        end
                    end
                    S_DROP:   if (is_last) state_next = S_IDLE;
                    default:  state_next = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Assembly registers are independent of the output slot
    always_ff @(posedge clk) begin
        if (latch_id) asm_id <= flit_data[ID_W-1:0];
        if (accept && is_pay) begin
            case (state)
                S_TS_MSB: ts[2*D-1:D] <= flit_data;
                S_TS_LSB: ts[D-1:0]   <= flit_data;
                S_R3_MSB: r3[2*D-1:D] <= flit_data;
                S_R3_LSB: r3[D-1:0]   <= flit_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trace_out_valid <= 1'b0;
            trace_out       <= '0;
            trace_core_id   <= '0;
        end else if (load_out) begin
            trace_out_valid <= 1'b1;
            trace_out       <= {ts, r3, flit_data};
            trace_core_id   <= asm_id;
        end else if (trace_out_ready) begin
            trace_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_drop  <= 1'b0;
            err_count <= '0;
        end else begin
            err_drop <= err_now;
            if (err_now && (err_count != {ERR_CNT_WIDTH{1'b1}}))
                err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_stm_trace_unpack.sv
// Directed self-checking bench for stm_trace_unpack: decode, backpressure,
// malformed-packet drops, error-counter saturation and mid-packet reset.
module tb_stm_trace_unpack;

    localparam logic [1:0] T_PAY  = 2'b00;
    localparam logic [1:0] T_HDR  = 2'b01;
    localparam logic [1:0] T_LAST = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] flit;
    logic        in_valid;
    logic        in_ready;
    logic [79:0] trace_out;
    logic [7:0]  core_id;
    logic        out_valid;
    logic        out_ready;
    logic        err_drop;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stm_trace_unpack dut (
        .clk             (clk),
        .rst             (rst),
        .dbgnoc_in_flit  (flit),
        .dbgnoc_in_valid (in_valid),
        .dbgnoc_in_ready (in_ready),
        .trace_out       (trace_out),
        .trace_core_id   (core_id),
        .trace_out_valid (out_valid),
        .trace_out_ready (out_ready),
        .err_drop        (err_drop),
        .err_count       (err_count)
    );

    // Presents one flit at a falling edge and returns at the falling edge
    // after the rising edge that accepted it.
    task automatic send(input logic [1:0] t, input logic [15:0] d, output int stalls);
        flit     = {t, d};
        in_valid = 1'b1;
        stalls   = 0;
        #1;
        while (!in_ready && stalls < 100) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic tx(input logic [1:0] t, input logic [15:0] d);
        int s;
        send(t, d, s);
    endtask

    task automatic packet(input logic [15:0] hdr, input logic [15:0] p0, input logic [15:0] p1,
                          input logic [15:0] p2, input logic [15:0] p3, input logic [15:0] last);
        tx(T_HDR, hdr);
        tx(T_PAY, p0);
        tx(T_PAY, p1);
        tx(T_PAY, p2);
        tx(T_PAY, p3);
        tx(T_LAST, last);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flit = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0)   begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (trace_out !== 80'h0)  begin failures++; $display("FAIL reset_trace: got %h expected 0", trace_out); end
        checks++; if (core_id !== 8'h00)    begin failures++; $display("FAIL reset_core_id: got %h expected 00", core_id); end
        checks++; if (err_count !== 8'h00)  begin failures++; $display("FAIL reset_err_count: got %h expected 00", err_count); end
        checks++; if (err_drop !== 1'b0)    begin failures++; $display("FAIL reset_err_drop: got %b expected 0", err_drop); end
        checks++; if (in_ready !== 1'b1)    begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single_packet();
        out_ready = 1'b1;
        packet(16'h0303, 16'h1234, 16'h5678, 16'hDEAD, 16'hBEEF, 16'h0008);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (trace_out !== 80'h12345678_DEADBEEF_0008)
            begin failures++; $display("FAIL single_trace: got %h expected 12345678deadbeef0008", trace_out); end
        checks++; if (core_id !== 8'h03)  begin failures++; $display("FAIL single_core_id: got %h expected 03", core_id); end
        checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL single_err_count: got %h expected 00", err_count); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int s;
        out_ready = 1'b0;
        packet(16'h0311, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'h1111);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid1: got %b expected 1", out_valid); end
        send(T_HDR, 16'h0322, s);
        checks++; if (s !== 0) begin failures++; $display("FAIL b2b_hdr_stall: got %0d expected 0", s); end
        tx(T_PAY, 16'h0102);
        tx(T_PAY, 16'h0304);
        tx(T_PAY, 16'h0506);
        tx(T_PAY, 16'h0708);
        flit = {T_LAST, 16'h090A};
        in_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_low[%0d]: got %b expected 0", i, in_ready); end
            checks++; if (trace_out !== 80'hAAAABBBB_CCCCDDDD_1111 || core_id !== 8'h11 || out_valid !== 1'b1)
                begin failures++; $display("FAIL b2b_hold[%0d]: got %h/%h/%b expected aaaabbbbccccdddd1111/11/1", i, trace_out, core_id, out_valid); end
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_release: got %b expected 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid2: got %b expected 1", out_valid); end
        checks++; if (trace_out !== 80'h01020304_05060708_090A)
            begin failures++; $display("FAIL b2b_trace2: got %h expected 0102030405060708090a", trace_out); end
        checks++; if (core_id !== 8'h22) begin failures++; $display("FAIL b2b_core_id2: got %h expected 22", core_id); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_truncated();
        out_ready = 1'b1;
        tx(T_HDR, 16'h0303);
        tx(T_PAY, 16'h1111);
        tx(T_PAY, 16'h2222);
        tx(T_LAST, 16'h3333);
        checks++; if (err_drop !== 1'b1)   begin failures++; $display("FAIL trunc_err_drop: got %b expected 1", err_drop); end
        checks++; if (err_count !== 8'h01) begin failures++; $display("FAIL trunc_err_count: got %h expected 01", err_count); end
        checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL trunc_no_record: got %b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (err_drop !== 1'b0)   begin failures++; $display("FAIL trunc_pulse_width: got %b expected 0", err_drop); end
        packet(16'h0307, 16'hCAFE, 16'hF00D, 16'h0BAD, 16'hC0DE, 16'h4242);
        checks++; if (out_valid !== 1'b1 || trace_out !== 80'hCAFEF00D_0BADC0DE_4242 || core_id !== 8'h07)
            begin failures++; $display("FAIL trunc_recover: got %b/%h/%h expected 1/cafef00d0badc0de4242/07", out_valid, trace_out, core_id); end
        checks++; if (err_count !== 8'h01) begin failures++; $display("FAIL trunc_count_stable: got %h expected 01", err_count); end
        @(negedge clk);
    endtask

    task automatic test_misclass();
        int s;
        out_ready = 1'b1;
        send(T_HDR, 16'h0205, s);
        checks++; if (err_drop !== 1'b1 || err_count !== 8'h02)
            begin failures++; $display("FAIL misclass_err: got %b/%h expected 1/02", err_drop, err_count); end
        tx(T_PAY, 16'h1234);
        tx(T_PAY, 16'h5678);
        tx(T_PAY, 16'h9ABC);
        tx(T_PAY, 16'hDEF0);
        send(T_LAST, 16'h0001, s);
        checks++; if (s !== 0) begin failures++; $display("FAIL misclass_stall: got %0d expected 0", s); end
        checks++; if (err_drop !== 1'b0 || err_count !== 8'h02)
            begin failures++; $display("FAIL misclass_single_err: got %b/%h expected 0/02", err_drop, err_count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL misclass_no_record: got %b expected 0", out_valid); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) tx(T_PAY, 16'h5A5A);
        checks++; if (err_count !== 8'hFF) begin failures++; $display("FAIL sat_count: got %h expected ff", err_count); end
        checks++; if (err_drop !== 1'b1)   begin failures++; $display("FAIL sat_err_drop: got %b expected 1", err_drop); end
        @(negedge clk);
        checks++; if (err_count !== 8'hFF) begin failures++; $display("FAIL sat_hold: got %h expected ff", err_count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        packet(16'h0309, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
        tx(T_HDR, 16'h0304);
        tx(T_PAY, 16'hAAAA);
        tx(T_PAY, 16'hBBBB);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
        checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL rstmid_count: got %h expected 00", err_count); end
        checks++; if (err_drop !== 1'b0)   begin failures++; $display("FAIL rstmid_err_drop: got %b expected 0", err_drop); end
        out_ready = 1'b1;
        tx(T_PAY, 16'hCCCC);
        checks++; if (err_count !== 8'h01) begin failures++; $display("FAIL rstmid_idle_state: got %h expected 01", err_count); end
        packet(16'h030C, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005);
        checks++; if (out_valid !== 1'b1 || trace_out !== 80'h00010002_00030004_0005 || core_id !== 8'h0C)
            begin failures++; $display("FAIL rstmid_next: got %b/%h/%h expected 1/00010002000300040005/0c", out_valid, trace_out, core_id); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_truncated();
        test_misclass();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
